// File: rtl/cmap_wb_scheduler_pkg.sv
// Shared types and default geometry for the channel-map write-back path
// (scheduler, channel-map buffer, Transpose FSM).
package cmap_wb_scheduler_pkg;

  localparam int CMAP_WIDTH     = 16;
  localparam int CMAP_SEL_W     = 5;
  localparam int CMAP_TILE_ID_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } wb_state_e;

endpackage

// File: rtl/cmap_wb_scheduler_if.sv
// Tile intake, channel-map buffer selector and write-back request bundle.
// master = scheduler side, slave = mapper/buffer/write-back side.
interface cmap_wb_scheduler_if
  import cmap_wb_scheduler_pkg::*;
#(
  parameter int TILE_ID_W = CMAP_TILE_ID_W,
  parameter int SEL_W     = CMAP_SEL_W
);
  logic                 tile_valid;
  logic [TILE_ID_W-1:0] tile_id;
  logic                 tile_ready;
  logic                 cmap_load;
  logic [SEL_W-1:0]     done;
  logic                 cmap_bit;
  logic                 wb_valid;
  logic [SEL_W-1:0]     wb_col;
  logic [TILE_ID_W-1:0] wb_tile_id;
  logic                 wb_ready;
  logic                 tile_done;

  modport master (
    input  tile_valid, tile_id, cmap_bit, wb_ready,
    output tile_ready, cmap_load, done, wb_valid, wb_col, wb_tile_id, tile_done
  );

  modport slave (
    output tile_valid, tile_id, cmap_bit, wb_ready,
    input  tile_ready, cmap_load, done, wb_valid, wb_col, wb_tile_id, tile_done
  );
endinterface

// File: rtl/cmap_wb_scheduler.sv
// Per-tile write-back sequencer: snapshots the channel map, walks the 1-based
// done selector over all channels and issues one request per set cmap bit.
module cmap_wb_scheduler
  import cmap_wb_scheduler_pkg::*;
#(
  parameter int WIDTH     = CMAP_WIDTH,
  parameter int TILE_ID_W = CMAP_TILE_ID_W,
  parameter int SEL_W     = CMAP_SEL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  cmap_wb_scheduler_if.master bus,
  output logic [SEL_W-1:0]    active_cnt,
  output logic                busy
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH);

  wb_state_e            state, state_nx;
  logic [SEL_W-1:0]     done_q, done_nx;
  logic [SEL_W-1:0]     cnt_nx;
  logic [TILE_ID_W-1:0] id_q, id_nx;
  logic                 hs_tile;
  logic                 adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      done_q     <= '0;
      id_q       <= '0;
      active_cnt <= '0;
    end else begin
      state      <= state_nx;
      done_q     <= done_nx;
      id_q       <= id_nx;
      active_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    done_nx        = done_q;
    id_nx          = id_q;
    cnt_nx         = active_cnt;
    hs_tile        = 1'b0;
    adv            = 1'b0;
    bus.tile_ready = 1'b0;
    bus.cmap_load  = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.wb_col     = '0;
    bus.tile_done  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        bus.tile_ready = 1'b1;
        // Load strobe is the handshake itself so the buffer captures on the accept edge.
        hs_tile        = bus.tile_valid && !abort;
        bus.cmap_load  = hs_tile;
        if (hs_tile) begin
          id_nx    = bus.tile_id;
          cnt_nx   = '0;
          done_nx  = SEL_W'(1);
          state_nx = ST_SCAN;
        end
      end
      ST_SCAN: begin
        bus.wb_valid = bus.cmap_bit;
        bus.wb_col   = done_q - 1'b1;
        adv          = !bus.cmap_bit || bus.wb_ready;
        if (adv) begin
          if (bus.cmap_bit) cnt_nx = active_cnt + 1'b1;
          if (done_q == LAST_SEL) begin
            done_nx  = '0;
            state_nx = ST_FINISH;
          end else begin
            done_nx  = done_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        bus.tile_done = 1'b1;
        state_nx      = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    // Flush wins over everything; a coincident wb handshake still completes
    // downstream but is not counted here.
    if (abort) begin
      state_nx = ST_IDLE;
      done_nx  = '0;
      cnt_nx   = active_cnt;
    end
  end

  assign bus.done       = done_q;
  assign bus.wb_tile_id = id_q;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_cmap_wb_scheduler.sv
// Bench for cmap_wb_scheduler: directed scenarios plus randomized tiles,
// checked against a per-channel expected timeline built from the cmap.
module tb_cmap_wb_scheduler;
  import cmap_wb_scheduler_pkg::*;

  localparam int W   = 16;
  localparam int IDW = 8;
  localparam int SW  = 5;

  typedef struct {
    int done;
    bit vld;
    bit rdy;
  } ent_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] active_cnt;
  logic          busy;
  logic [W-1:0]  snap;
  logic [W-1:0]  cmap_in = '0;
  int            checks  = 0;
  int            errors  = 0;

  cmap_wb_scheduler_if #(.TILE_ID_W(IDW), .SEL_W(SW)) bus ();

  cmap_wb_scheduler #(.WIDTH(W), .TILE_ID_W(IDW), .SEL_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort      (abort),
    .bus        (bus),
    .active_cnt (active_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Channel-map buffer stand-in: snapshot on load, combinational read by done.
  always_ff @(posedge clk) if (bus.cmap_load) snap <= cmap_in;

  always_comb begin
    int d;
    d = int'(bus.done);
    bus.cmap_bit = 1'b0;
    if (d >= 1 && d <= W) bus.cmap_bit = snap[d-1];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    #2;
    chk({tag, "_tile_ready"}, bus.tile_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_wb_valid"}, bus.wb_valid, 0);
    chk({tag, "_tile_done"}, bus.tile_done, 0);
  endtask

  // One tile from handshake to FINISH; returns in the following IDLE cycle.
  task automatic run_tile(input logic [W-1:0] cmap, input logic [IDW-1:0] id,
                          input int smin, input int smax, input bit keep,
                          input logic [W-1:0] ncmap, input logic [IDW-1:0] nid);
    ent_t q[$];
    int   cnt;
    int   s;
    int   stalls;
    cnt    = 0;
    stalls = 0;
    for (int k = 0; k < W; k++) begin
      s = cmap[k] ? int'($urandom_range(smax, smin)) : 0;
      stalls += s;
      for (int j = 0; j < s; j++) q.push_back('{k + 1, 1'b1, 1'b0});
      q.push_back('{k + 1, cmap[k], cmap[k] ? 1'b1 : 1'($urandom_range(1, 0))});
    end
    bus.tile_valid = 1'b1;
    bus.tile_id    = id;
    cmap_in        = cmap;
    bus.wb_ready   = 1'b0;
    #2;
    chk("hs_tile_ready", bus.tile_ready, 1);
    chk("hs_cmap_load", bus.cmap_load, 1);
    tick();
    bus.tile_valid = keep;
    bus.tile_id    = nid;
    cmap_in        = ncmap;
    foreach (q[i]) begin
      bus.wb_ready = q[i].rdy;
      #2;
      chk("scan_done", bus.done, q[i].done);
      chk("scan_wb_valid", bus.wb_valid, q[i].vld);
      if (q[i].vld) begin
        chk("scan_wb_col", bus.wb_col, q[i].done - 1);
        chk("scan_wb_tile_id", bus.wb_tile_id, id);
      end
      chk("scan_tile_ready", bus.tile_ready, 0);
      chk("scan_cmap_load", bus.cmap_load, 0);
      chk("scan_tile_done", bus.tile_done, 0);
      if (q[i].vld && q[i].rdy) cnt++;
      tick();
    end
    bus.wb_ready = 1'b0;
    #2;
    chk("fin_cycles", q.size(), W + stalls);
    chk("fin_tile_done", bus.tile_done, 1);
    chk("fin_done", bus.done, 0);
    chk("fin_wb_valid", bus.wb_valid, 0);
    chk("fin_cmap_load", bus.cmap_load, 0);
    chk("fin_tile_ready", bus.tile_ready, 0);
    chk("fin_active_cnt", active_cnt, cnt);
    chk("fin_popcount", active_cnt, $countones(cmap));
    tick();
  endtask

  initial begin
    bus.tile_valid = 1'b0;
    bus.tile_id    = '0;
    bus.wb_ready   = 1'b0;
    #3;
    chk("rst_tile_ready", bus.tile_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_cmap_load", bus.cmap_load, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_col", bus.wb_col, 0);
    chk("rst_wb_tile_id", bus.wb_tile_id, 0);
    chk("rst_tile_done", bus.tile_done, 0);
    chk("rst_active_cnt", active_cnt, 0);
    chk("rst_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // All-zero map, full map, and sparse map with fixed 3-cycle stalls.
    run_tile(16'h0000, 8'h3A, 0, 0, 1'b0, '0, '0);
    idle_chk("zero_idle");
    run_tile(16'hFFFF, 8'h3A, 0, 0, 1'b0, '0, '0);
    idle_chk("full_idle");
    run_tile(16'h8001, 8'h3A, 3, 3, 1'b0, '0, '0);
    idle_chk("stall_idle");

    // tile_valid held through the first tile; second accepted only afterwards.
    run_tile(16'h0F0F, 8'h11, 0, 1, 1'b1, 16'hF0F0, 8'h55);
    run_tile(16'hF0F0, 8'h55, 0, 1, 1'b0, '0, '0);
    idle_chk("back2back_idle");

    // Abort at done=6 coinciding with a wb handshake.
    bus.tile_valid = 1'b1;
    bus.tile_id    = 8'h42;
    cmap_in        = 16'h00F0;
    tick();
    bus.tile_valid = 1'b0;
    bus.wb_ready   = 1'b1;
    for (int d = 1; d <= 5; d++) begin
      #2;
      chk("abort_walk_done", bus.done, d);
      tick();
    end
    abort = 1'b1;
    #2;
    chk("abort_done6", bus.done, 6);
    chk("abort_wb_valid", bus.wb_valid, 1);
    tick();
    abort = 1'b0;
    bus.wb_ready = 1'b0;
    idle_chk("abort_after");
    chk("abort_active_cnt", active_cnt, 1);
    tick();
    #2;
    chk("abort_no_tile_done", bus.tile_done, 0);
    tick();

    // Abort in IDLE blocks acceptance.
    bus.tile_valid = 1'b1;
    abort = 1'b1;
    #2;
    chk("abort_idle_cmap_load", bus.cmap_load, 0);
    tick();
    bus.tile_valid = 1'b0;
    abort = 1'b0;
    idle_chk("abort_idle_after");
    tick();
    run_tile(16'h00F0, 8'h43, 0, 2, 1'b0, '0, '0);
    idle_chk("post_abort_idle");

    // Async reset mid-scan while stalled on channel 1 of 16'hAAAA.
    bus.tile_valid = 1'b1;
    bus.tile_id    = 8'h77;
    cmap_in        = 16'hAAAA;
    tick();
    bus.tile_valid = 1'b0;
    bus.wb_ready   = 1'b0;
    tick();
    tick();
    #2;
    chk("rstmid_wb_valid_pre", bus.wb_valid, 1);
    chk("rstmid_done_pre", bus.done, 2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", bus.done, 0);
    chk("rstmid_wb_valid", bus.wb_valid, 0);
    chk("rstmid_wb_tile_id", bus.wb_tile_id, 0);
    chk("rstmid_wb_col", bus.wb_col, 0);
    chk("rstmid_active_cnt", active_cnt, 0);
    chk("rstmid_tile_ready", bus.tile_ready, 1);
    chk("rstmid_tile_done", bus.tile_done, 0);
    tick();
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_chk("rstmid_release");
    end
    tick();

    for (int r = 0; r < 8; r++) begin
      run_tile(W'($urandom), IDW'($urandom), 0, 2, 1'b0, '0, '0);
      idle_chk("rand_idle");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
